// File: rtl/prim_arb_pkg.sv
// prim_arb_pkg: definitions shared by the arbiter request FIFO and its
// pointer/occupancy sub-module.
//   DefaultDepth - default FIFO entry count
//   ptr_inc()    - advance a pointer by one, wrapping from depth-1 to 0
package prim_arb_pkg;

    localparam int unsigned DefaultDepth = 4;

    // Wraps at an arbitrary depth so that non-power-of-2 FIFOs use every entry.
    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/prim_arb_req_fifo_cnt.sv
// prim_arb_req_fifo_cnt: read/write pointers and occupancy counter for
// prim_arb_req_fifo. Flush (clr_i) wins over push and pop.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   clr_i           - synchronous flush
//   push_i, pop_i   - qualified push / pop strobes from the FIFO top
//   wr_ptr_o        - next write index
//   rd_ptr_o        - head index
//   depth_o         - number of stored entries (0..Depth)
module prim_arb_req_fifo_cnt
    import prim_arb_pkg::*;
#(
    parameter  int unsigned Depth = DefaultDepth,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            push_i,
    input  logic            pop_i,
    output logic [PtrW-1:0] wr_ptr_o,
    output logic [PtrW-1:0] rd_ptr_o,
    output logic [CntW-1:0] depth_o
);

    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= PtrW'(ptr_inc(32'(wr_ptr_q), Depth));
            end
            if (pop_i) begin
                rd_ptr_q <= PtrW'(ptr_inc(32'(rd_ptr_q), Depth));
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign depth_o  = cnt_q;

endmodule

// File: rtl/prim_arb_req_fifo.sv
// prim_arb_req_fifo: request FIFO feeding one port of an arbiter. The head
// entry is presented as req_o/data_o and is popped on gnt_i.
// Optional macro PRIM_ARB_REQ_FIFO_PASSTHRU_EN adds a zero-latency
// fall-through path while the FIFO is empty.
// Parameters: DW (data width), Depth (entries, >= 2)
// Ports:
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   clr_i                - synchronous flush, overrides push and pop
//   wvalid_i/wready_o    - upstream write handshake, wdata_i write data
//   req_o/data_o         - request and head data to the arbiter
//   gnt_i                - grant from the arbiter
//   depth_o              - current occupancy
//   err_o                - one-cycle pulse after a grant with no request
module prim_arb_req_fifo
    import prim_arb_pkg::*;
#(
    parameter  int unsigned DW    = 32,
    parameter  int unsigned Depth = DefaultDepth,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            wvalid_i,
    output logic            wready_o,
    input  logic [DW-1:0]   wdata_i,
    output logic            req_o,
    output logic [DW-1:0]   data_o,
    input  logic            gnt_i,
    output logic [CntW-1:0] depth_o,
    output logic            err_o
);

    if (Depth < 2) begin : g_bad_depth
        $error("prim_arb_req_fifo: Depth must be at least 2");
    end

    logic [DW-1:0]   mem_q [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            empty;
    logic            full;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            err_q;

    assign empty = (depth_o == '0);
    assign full  = (depth_o == CntW'(Depth));

`ifdef PRIM_ARB_REQ_FIFO_PASSTHRU_EN
    // Empty FIFO forwards the incoming word straight to the arbiter.
    assign bypass = empty && wvalid_i && !clr_i;
`else
    assign bypass = 1'b0;
`endif

    // Full is judged on registered occupancy only, so a same-cycle pop
    // never opens the write port.
    assign wready_o = !full && !clr_i;
    assign req_o    = (!empty || bypass) && !clr_i;

    always_comb begin
        data_o = '0;
        if (!empty) begin
            data_o = mem_q[rd_ptr];
        end else if (bypass) begin
            data_o = wdata_i;
        end
    end

    // A granted bypass word is consumed without being stored.
    assign pop  = gnt_i && req_o && !empty;
    assign push = wvalid_i && wready_o && !(bypass && gnt_i);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= gnt_i && !req_o && !clr_i;
        end
    end

    assign err_o = err_q;

    prim_arb_req_fifo_cnt #(
        .Depth (Depth)
    ) u_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clr_i),
        .push_i   (push),
        .pop_i    (pop),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .depth_o  (depth_o)
    );

endmodule

// File: doc/prim_arb_req_fifo.md
PRIM_ARB_REQ_FIFO -- requirements
Module: prim_arb_req_fifo

Interface
REQ-001 Parameter DW, default 32, data width; SHALL equal the DW of the arbiter port it feeds.
REQ-002 Parameter Depth, default 4, number of entries; Depth >= 2 SHALL be enforced by elaboration-time assertion.
REQ-003 Derived localparam PtrW = $clog2(Depth) and CntW = $clog2(Depth+1); neither SHALL be overridable.
REQ-004 clk_i  input  1  single clock; all state SHALL be on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 clr_i  input  1  synchronous flush.
REQ-007 wvalid_i  input  1  upstream write valid.
REQ-008 wready_o  output  1  write ready.
REQ-009 wdata_i  input  DW  write data.
REQ-010 req_o  output  1  request to one arbiter port (drives req_i[k]).
REQ-011 data_o  output  DW  head data (drives data_i[k]).
REQ-012 gnt_i  input  1  grant from the arbiter (gnt_o[k]).
REQ-013 depth_o  output  CntW  current occupancy.
REQ-014 err_o  output  1  protocol error pulse.

Function
REQ-015 Push SHALL occur when wvalid_i && wready_o && !clr_i; wdata_i is written at wr_ptr and wr_ptr increments.
REQ-016 Pop SHALL occur when gnt_i && req_o && !clr_i; rd_ptr increments.
REQ-017 Pointers SHALL wrap from Depth-1 to 0, with no wasted entry for non-power-of-2 Depth.
REQ-018 wready_o SHALL be (depth_o != Depth) && !clr_i, and SHALL NOT depend combinationally on gnt_i; when full, a same-cycle pop does not enable a push.
REQ-019 req_o SHALL be (depth_o != 0) && !clr_i; once asserted, req_o and data_o SHALL hold stable until the pop.
REQ-020 data_o SHALL be the entry at rd_ptr, and '0 when empty.
REQ-021 A simultaneous push and pop SHALL leave depth_o unchanged and move both pointers.
REQ-022 depth_o SHALL increment on push-only, decrement on pop-only, and never exceed Depth or go below 0.
REQ-023 clr_i SHALL take priority over push and pop: next cycle, pointers = 0, depth_o = 0, and err_o is not raised.
REQ-024 err_o SHALL pulse high for exactly one cycle, registered, the cycle after gnt_i is high while req_o is low.
REQ-025 Push-to-req_o latency SHALL be 1 cycle (data is visible the cycle after the push).

Reset
REQ-026 While rst_ni = 0: pointers = 0, depth_o = 0, req_o = 0, err_o = 0, data_o = '0, wready_o = 1.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately; storage contents need not be reset.

Configuration
REQ-028 Macro PRIM_ARB_REQ_FIFO_PASSTHRU_EN, when defined, SHALL add fall-through when empty: req_o = wvalid_i and data_o = wdata_i (0-cycle latency).
REQ-029 With the macro defined, empty && wvalid_i && gnt_i SHALL consume the word without storing it (depth_o stays 0), and wready_o = 1.
REQ-030 Without the macro, behaviour SHALL be exactly REQ-019/020/025 and wvalid_i never reaches req_o combinationally.

Structure
REQ-031 Shared package prim_arb_pkg SHALL hold the DefaultDepth constant and the pointer-increment-with-wrap function.
REQ-032 One sub-module, prim_arb_req_fifo_cnt, SHALL hold the rd/wr pointers and the occupancy counter; the storage array stays in the top.

Verification
REQ-033 Depth=4: push 0xA1,0xA2,0xA3,0xA4 with gnt_i=0 -> depth_o=4, wready_o=0, req_o=1, and data_o holds 0xA1 stable for all cycles.
REQ-034 From full, gnt_i=1 for 4 cycles -> data_o sequence 0xA1..0xA4, then req_o=0, depth_o=0, and no write accepted while full.
REQ-035 Depth=3: 10 pushes interleaved with 10 pops via continuous push+pop -> in-order data across wrap, and depth_o never exceeds 3.
REQ-036 gnt_i=1 while empty (no passthru) -> err_o=1 for exactly one cycle, and state unchanged; clr_i=1 with depth_o=2 -> depth_o=0 and req_o=0 the next cycle.
REQ-037 PASSTHRU_EN, empty, wvalid_i=1, wdata_i=0x55, gnt_i=1 -> req_o=1, data_o=0x55 the same cycle, depth_o stays 0.
REQ-038 Assert rst_ni=0 with depth_o=3 -> req_o=0, depth_o=0, and wready_o=1 asynchronously before the next clock edge.
